// File: rtl/hilo_div_pkg.sv
// Shared constants and helpers for the HI/LO multi-cycle divider.
// State encodings match the legacy DivFree/DivByZero/DivOn/DivEnd values.
package hilo_div_pkg;

  localparam int HiloBusW = 66;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // 0x80000000 maps onto itself, which is the right unsigned magnitude.
  function automatic logic [31:0] abs_mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/hilo_div.sv
// Multi-cycle restoring divider for div/divu; emits one HI/LO write
// (remainder to HI, quotient to LO) and stalls the pipeline meanwhile.
module hilo_div
  import hilo_div_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                start,
  input  logic                signed_op,
  input  logic [31:0]         dividend,
  input  logic [31:0]         divisor,
  output logic                stallreq,
  output logic [HiloBusW-1:0] hilo_bus,
  output logic                busy
);

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [31:0]         dvd_r;
  logic [31:0]         dvs_r;
  logic [31:0]         rem_r;
  logic [31:0]         quo_r;
  logic [4:0]          cnt_r;
  logic                quo_neg_r;
  logic                rem_neg_r;
  logic                busy_r;
  logic [HiloBusW-1:0] hilo_bus_r;

  logic                accept_s;
  logic [32:0]         rem_shift_s;
  logic                fits_s;
  logic [31:0]         diff_s;
  logic [31:0]         rem_nxt_s;
  logic [31:0]         quo_nxt_s;
  logic [31:0]         quo_fix_s;
  logic [31:0]         rem_fix_s;

  assign accept_s = (state_r == DivFree) && start && !flush;
  assign stallreq = accept_s || (state_r == DivOn) || (state_r == DivByZero);
  assign hilo_bus = hilo_bus_r;
  assign busy     = busy_r;

  // One restoring step: shift in the next dividend bit, keep the trial difference if it fits.
  always_comb begin
    rem_shift_s = {rem_r, dvd_r[31]};
    fits_s      = (rem_shift_s >= {1'b0, dvs_r});
    diff_s      = rem_shift_s[31:0] - dvs_r;
    if (fits_s) begin
      rem_nxt_s = diff_s;
      quo_nxt_s = {quo_r[30:0], 1'b1};
    end else begin
      rem_nxt_s = rem_shift_s[31:0];
      quo_nxt_s = {quo_r[30:0], 1'b0};
    end
    quo_fix_s = quo_neg_r ? neg32(quo_nxt_s) : quo_nxt_s;
    rem_fix_s = rem_neg_r ? neg32(rem_nxt_s) : rem_nxt_s;
  end

  // Next-state selection; flush wins over everything.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = DivFree;
    end else begin
      case (state_r)
        DivFree: begin
          if (start) begin
            state_nxt_s = (divisor == 32'd0) ? DivByZero : DivOn;
          end else begin
            state_nxt_s = DivFree;
          end
        end
        DivByZero: state_nxt_s = DivEnd;
        DivOn: begin
          if (cnt_r == 5'd31) begin
            state_nxt_s = DivEnd;
          end else begin
            state_nxt_s = DivOn;
          end
        end
        DivEnd:  state_nxt_s = DivFree;
        default: state_nxt_s = DivFree;
      endcase
    end
  end

  // State, datapath and the one-cycle result write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= DivFree;
      busy_r     <= 1'b0;
      dvd_r      <= 32'd0;
      dvs_r      <= 32'd0;
      rem_r      <= 32'd0;
      quo_r      <= 32'd0;
      cnt_r      <= 5'd0;
      quo_neg_r  <= 1'b0;
      rem_neg_r  <= 1'b0;
      hilo_bus_r <= {HiloBusW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s != DivFree);
      hilo_bus_r <= {HiloBusW{1'b0}};
      if (accept_s) begin
        dvd_r     <= abs_mag(dividend, signed_op);
        dvs_r     <= abs_mag(divisor, signed_op);
        quo_neg_r <= signed_op && (dividend[31] ^ divisor[31]);
        rem_neg_r <= signed_op && dividend[31];
        rem_r     <= 32'd0;
        quo_r     <= 32'd0;
        cnt_r     <= 5'd0;
      end else if ((state_r == DivOn) && !flush) begin
        dvd_r <= {dvd_r[30:0], 1'b0};
        rem_r <= rem_nxt_s;
        quo_r <= quo_nxt_s;
        cnt_r <= cnt_r + 5'd1;
        if (cnt_r == 5'd31) begin
          hilo_bus_r <= {1'b1, 1'b1, rem_fix_s, quo_fix_s};
        end
      end else if ((state_r == DivByZero) && !flush) begin
        hilo_bus_r <= {1'b1, 1'b1, 32'd0, 32'd0};
      end
    end
  end

endmodule

// File: doc/hilo_div.md
# hilo_div

Multi-cycle 32-bit integer divider that produces the 66-bit HI/LO write bus consumed by the HI/LO register in the SampleCPU core. It sits in the EX stage, accepts `div`/`divu` operands, stalls the pipeline for the duration of the operation, and emits one write carrying quotient to LO and remainder to HI. Ordinary EX-stage forwarding of `hilo_bus` is unchanged; this block is just another source of it.

## Interface
- Parameters: none; widths fixed at 32-bit data and 66-bit bus (`HiloBus` in `defines.vh`).
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  cancel any operation; no write issued
- start  in  1  request a divide; held high by the stalled pipeline until completion
- signed_op  in  1  1 = `div` (two's complement), 0 = `divu`
- dividend  in  32  operand rs
- divisor  in  32  operand rt
- stallreq  out  1  pipeline stall request
- hilo_bus  out  66  {hi_we, lo_we, hi_data, lo_data}; hi_data = remainder, lo_data = quotient
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ZERO, ON, END (encodings in `defines.vh`).
- IDLE: if start && !flush:
  - divisor == 0 → ZERO.
  - else latch |dividend|, |divisor|, quotient sign, remainder sign; clear count → ON.
- Absolute values: only when signed_op and operand bit 31 set. Unsigned magnitude math, so 0x80000000 stays 0x80000000.
- ON: restoring division, one quotient bit per cycle, MSB first.
  - 33-bit partial remainder; shift in next dividend bit.
  - Trial subtract of divisor; keep the result if non-negative and shift quotient bit 1, else 0.
  - After 32 iterations (count == 31 processed) → END.
- Sign fixup, applied entering END:
  - quotient negated when signed_op && (dividend[31] ^ divisor[31]).
  - remainder negated when signed_op && dividend[31].
- ZERO: result quotient = 0, remainder = 0 → END next cycle.
- END: drive hilo_bus = {1, 1, remainder, quotient} for exactly one cycle → IDLE unconditionally. start is ignored in END.
- hilo_bus = 66'b0 in every state except END.
- stallreq = (IDLE && start && !flush) || ON || ZERO.
  - stallreq is 0 in END, so the pipeline advances on the same cycle the write is presented.
- flush in any state: next state IDLE, no write; it overrides start in the same cycle.
- rst: state IDLE, datapath registers 0, all outputs 0. Reset mid-operation discards the result.

## Timing
- Start sampled in IDLE at cycle 0.
- Nonzero divisor: ON cycles 1–32, END at cycle 33, IDLE at cycle 34. Latency 33 cycles from start to hilo_bus valid.
- Zero divisor: ZERO at cycle 1, END at cycle 2.
- Back-to-back divides: second start is accepted no earlier than the cycle after END (cycle 34).
- stallreq is combinational from state and start. Everything else is registered.
- Operands are sampled only at acceptance; later changes on the inputs have no effect.

## Structure
- `defines.vh`: state encodings `DivFree`/`DivByZero`/`DivOn`/`DivEnd`, `HiloBus` = 66, and the existing `StallBus`.
- Single module; no sub-module. The iteration step is a plain subtract and needs no separate block.
- The EX stage ORs `stallreq` into the stall controller and forwards `hilo_bus` on the EX bus path.

## Test plan
- divu 100 / 7 → cycle 33: hilo_bus = {1, 1, 0x00000002, 0x0000000E}; stallreq high cycles 0–32, low at 33.
- div −7 / 2 (0xFFFFFFF9, 0x00000002) → lo 0xFFFFFFFD, hi 0xFFFFFFFF. divu of the same operands → lo 0x7FFFFFFC, hi 0x00000001.
- div 0x80000000 / 0xFFFFFFFF → lo 0x80000000, hi 0; no hang.
- Divide by zero (5 / 0) → END at cycle 2 with hi = lo = 0; total stall 2 cycles.
- flush at cycle 10 of ON → IDLE at cycle 11, hilo_bus stays 0. A new start at cycle 12 completes correctly at cycle 45.
- rst asserted at cycle 20 → all outputs 0 the next cycle. Back-to-back divides 9/3 then 10/4: second result {1, 1, 2, 2} exactly 34 cycles after the first END.
